bus_responder: RTL and testbench
================================

Name: bus_responder

Overview:
- Slave-side end of the request/response serial bus.
- Sits between a UART receiver/transmitter pair and a local data source such as a sensor register.
- Waits for a request byte equal to its node address, samples the local data, then computes a CRC-8 over it serially.
- Transmits a two-byte reply through the UART transmitter handshake: data byte first, then CRC byte.

Parameters:
- ADDR, 8'h01: request byte this node answers to.
- POLY, 8'h07: CRC-8 generator polynomial (x^8 implicit).
- CRC_INIT, 8'h00: CRC register initial value.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_rx  input  8  byte from the UART receiver.
- done_rx  input  1  receiver byte-complete strobe; data_rx is valid while it is high.
- active_tx  input  1  transmitter currently shifting a frame.
- done_tx  input  1  transmitter frame-complete flag.
- sample_data  input  8  local data to report.
- data_tx  output  8  byte presented to the transmitter.
- enable_tx  output  1  one-cycle transmit start pulse.
- busy  output  1  high whenever the state is not IDLE.
- req_count  output  8  number of completed replies, wraps 8'hFF to 8'h00.

Behaviour:
- Reset values: data_tx=0, enable_tx=0, busy=0, req_count=0. Internal registers are cleared (data latch=0, crc=CRC_INIT, bit counter=0) and state=IDLE.
- Reset is asynchronous. Asserting it mid-operation aborts any reply and drops enable_tx immediately.
- States: IDLE, CRC, FREE1, SEND1, WAIT1, FREE2, SEND2, WAIT2.
- IDLE:
  - On a clock edge with done_rx=1 and data_rx==ADDR: latch sample_data into the data latch, load crc=CRC_INIT, clear the bit counter, go to CRC.
  - done_rx with any other byte is ignored and the state stays IDLE.
- CRC: one bit per cycle, MSB first, for exactly 8 cycles.
  - fb = crc[7] XOR data[7-cnt]
  - crc = {crc[6:0],1'b0} XOR (fb ? POLY : 0)
  - After the 8th bit, go to FREE1.
  - No reflection and no final XOR.
- FREE1: stay while (active_tx | done_tx); otherwise go to SEND1.
- SEND1: data_tx<=data latch, enable_tx<=1 for exactly one cycle, go to WAIT1.
- WAIT1: enable_tx<=0. Stay until done_tx=1, then go to FREE2.
- FREE2: stay while (active_tx | done_tx), then go to SEND2.
- SEND2: data_tx<=crc, one-cycle enable_tx pulse, go to WAIT2.
- WAIT2: wait for done_tx=1, then req_count<=req_count+1 and go to IDLE.
- data_tx holds its last value between sends.
- Latency: with the transmitter idle, the first enable_tx rises 10 clock edges after the edge that sampled the matching done_rx.
- done_rx outside IDLE is ignored. A request arriving mid-reply is dropped and does not restart the reply.
- sample_data changes after the capture edge do not affect the reply in progress.
- done_tx already high when the block enters FREE1/FREE2 delays transmission until it falls. The block never issues enable_tx while active_tx or done_tx is high.
- enable_tx is never high for more than one consecutive cycle.
- busy is a decode of state!=IDLE.

Test Plan:
- Reset, then done_rx with data_rx=8'h01 and sample_data=8'h31, transmitter idle -> enable_tx rises 10 edges later with data_tx=8'h31. After done_tx, the second pulse carries data_tx=8'h97 and req_count=1.
- sample_data=8'h01 -> CRC byte 8'h07. sample_data=8'hFF -> 8'hF3. sample_data=8'h00 -> 8'h00.
- done_rx with data_rx=8'h02 -> no enable_tx, busy stays 0, req_count unchanged.
- active_tx held high for 20 cycles at FREE1 -> enable_tx withheld until active_tx and done_tx are both low, then exactly one pulse.
- Second matching done_rx during WAIT1 -> ignored; exactly two enable_tx pulses total; req_count increments by 1.
- Reset asserted during WAIT1 -> outputs return to reset values at once. A new request afterwards replies normally. 256 completed replies -> req_count wraps to 0.

Source files
------------

// File: rtl/bus_responder_if.sv
// Byte-level handshake between the UART receiver/transmitter pair and the responder.
interface bus_responder_if;
    localparam int unsigned DATA_W = 8;

    logic [DATA_W-1:0] data_rx;
    logic              done_rx;
    logic              active_tx;
    logic              done_tx;
    logic [DATA_W-1:0] data_tx;
    logic              enable_tx;

    // Responder side: consumes receiver bytes and transmitter status, drives transmit requests.
    modport slave (
        input  data_rx,
        input  done_rx,
        input  active_tx,
        input  done_tx,
        output data_tx,
        output enable_tx
    );

    // UART side: produces received bytes and transmitter status, consumes transmit requests.
    modport master (
        output data_rx,
        output done_rx,
        output active_tx,
        output done_tx,
        input  data_tx,
        input  enable_tx
    );
endinterface

// File: rtl/bus_responder.sv
// Serial-bus slave: answers its address with {sample byte, CRC-8 of that byte}.
module bus_responder #(
    parameter logic [7:0] ADDR     = 8'h01,
    parameter logic [7:0] POLY     = 8'h07,
    parameter logic [7:0] CRC_INIT = 8'h00
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_responder_if.slave        bus,
    input  logic [7:0]            sample_data,
    output logic                  busy,
    output logic [7:0]            req_count
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CRC,
        FREE1,
        SEND1,
        WAIT1,
        FREE2,
        SEND2,
        WAIT2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic [DATA_W-1:0]   crc_q, crc_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic [DATA_W-1:0]   data_tx_q, data_tx_nxt;
    logic                enable_tx_q, enable_tx_nxt;
    logic [DATA_W-1:0]   req_count_q, req_count_nxt;
    logic                busy_q;
    logic                fb;
    logic                tx_in_use;

    assign tx_in_use     = bus.active_tx | bus.done_tx;
    assign bus.data_tx   = data_tx_q;
    assign bus.enable_tx = enable_tx_q;
    assign busy          = busy_q;
    assign req_count     = req_count_q;

    // State and output registers; reset aborts any reply in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_q      <= '0;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            data_tx_q   <= '0;
            enable_tx_q <= 1'b0;
            req_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_q      <= data_nxt;
            crc_q       <= crc_nxt;
            cnt_q       <= cnt_nxt;
            data_tx_q   <= data_tx_nxt;
            enable_tx_q <= enable_tx_nxt;
            req_count_q <= req_count_nxt;
            busy_q      <= (state_nxt != IDLE);
        end
    end

    // Next-state decode, bit-serial CRC step and transmit sequencing.
    always_comb begin
        state_nxt     = state;
        data_nxt      = data_q;
        crc_nxt       = crc_q;
        cnt_nxt       = cnt_q;
        data_tx_nxt   = data_tx_q;
        enable_tx_nxt = 1'b0;
        req_count_nxt = req_count_q;
        fb            = 1'b0;

        case (state)
            IDLE: begin
                if (bus.done_rx && (bus.data_rx == ADDR)) begin
                    data_nxt  = sample_data;
                    crc_nxt   = CRC_INIT;
                    cnt_nxt   = '0;
                    state_nxt = CRC;
                end
            end
            CRC: begin
                fb      = crc_q[7] ^ data_q[CNT_W'(3'd7 - cnt_q)];
                crc_nxt = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) begin
                    state_nxt = FREE1;
                end
            end
            FREE1: begin
                if (!tx_in_use) begin
                    state_nxt = SEND1;
                end
            end
            SEND1: begin
                data_tx_nxt   = data_q;
                enable_tx_nxt = 1'b1;
                state_nxt     = WAIT1;
            end
            WAIT1: begin
                if (bus.done_tx) begin
                    state_nxt = FREE2;
                end
            end
            FREE2: begin
                if (!tx_in_use) begin
                    state_nxt = SEND2;
                end
            end
            SEND2: begin
                data_tx_nxt   = crc_q;
                enable_tx_nxt = 1'b1;
                state_nxt     = WAIT2;
            end
            WAIT2: begin
                if (bus.done_tx) begin
                    req_count_nxt = req_count_q + DATA_W'(1);
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder with a simple UART transmitter model.
module tb_bus_responder;
    localparam int TX_LEN = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sample_data = 8'h00;
    logic       busy;
    logic [7:0] req_count;

    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    logic       hold_active = 1'b0;
    logic       hold_done = 1'b0;
    int         tx_cnt = 0;

    int         n_checks = 0;
    int         n_pass = 0;
    int         pulse_cnt = 0;
    int         dbl_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_en = 1'b0;
    logic [7:0] exp_req = 8'h00;

    bus_responder_if bus ();

    assign bus.active_tx = m_active | hold_active;
    assign bus.done_tx   = m_done | hold_done;

    bus_responder #(
        .ADDR     (8'h01),
        .POLY     (8'h07),
        .CRC_INIT (8'h00)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .sample_data (sample_data),
        .busy        (busy),
        .req_count   (req_count)
    );

    always #5 clock = ~clock;

    // Transmitter model: a frame of TX_LEN cycles then a one-cycle done_tx.
    always @(negedge clock) begin
        if (tx_cnt == 0) begin
            m_done = 1'b0;
            if (bus.enable_tx) begin
                m_active = 1'b1;
                tx_cnt   = 1;
            end
        end else if (tx_cnt < TX_LEN) begin
            tx_cnt = tx_cnt + 1;
        end else begin
            m_active = 1'b0;
            m_done   = 1'b1;
            tx_cnt   = 0;
        end
    end

    // Pulse monitor: counts enable_tx pulses and protocol violations.
    always @(posedge clock) begin
        #1;
        if (bus.enable_tx) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_en) dbl_cnt = dbl_cnt + 1;
            if (bus.active_tx || bus.done_tx) viol_cnt = viol_cnt + 1;
        end
        prev_en = bus.enable_tx;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_req(input logic [7:0] addr, input logic [7:0] sample);
        bus.data_rx = addr;
        bus.done_rx = 1'b1;
        sample_data = sample;
        tick();
        bus.done_rx = 1'b0;
        sample_data = ~sample;
    endtask

    task automatic wait_pulse(input string tag);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus.enable_tx) break;
        end
        check(tag, 32'(bus.enable_tx), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reply(input logic [7:0] sample, input logic [7:0] crc, input string tag);
        send_req(8'h01, sample);
        wait_pulse({tag, "_p1"});
        check({tag, "_data"}, 32'(bus.data_tx), 32'(sample));
        wait_pulse({tag, "_p2"});
        check({tag, "_crc"}, 32'(bus.data_tx), 32'(crc));
        wait_idle({tag, "_idle"});
        exp_req = exp_req + 8'd1;
        check({tag, "_cnt"}, 32'(req_count), 32'(exp_req));
    endtask

    task automatic hold_test(input logic use_done, input string tag);
        int p0;
        p0 = pulse_cnt;
        if (use_done) hold_done = 1'b1;
        else hold_active = 1'b1;
        send_req(8'h01, 8'h31);
        repeat (20) tick();
        check({tag, "_held"}, 32'(pulse_cnt - p0), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        hold_active = 1'b0;
        hold_done   = 1'b0;
        wait_pulse({tag, "_p1"});
        check({tag, "_data"}, 32'(bus.data_tx), 32'h31);
        wait_pulse({tag, "_p2"});
        check({tag, "_crc"}, 32'(bus.data_tx), 32'h97);
        wait_idle({tag, "_idle"});
        exp_req = exp_req + 8'd1;
        check({tag, "_pulses"}, 32'(pulse_cnt - p0), 32'd2);
    endtask

    initial begin
        int p0;
        bus.data_rx = 8'h00;
        bus.done_rx = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_data_tx", 32'(bus.data_tx), 32'h00);
        check("rst_enable_tx", 32'(bus.enable_tx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_count", 32'(req_count), 32'h00);
        reset = 1'b0;
        tick();

        // First reply: latency and data/CRC bytes
        send_req(8'h01, 8'h31);
        check("lat_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        check("lat_pre", 32'(bus.enable_tx), 32'd0);
        tick();
        check("lat_en", 32'(bus.enable_tx), 32'd1);
        check("lat_data", 32'(bus.data_tx), 32'h31);
        wait_pulse("lat_p2");
        check("lat_crc", 32'(bus.data_tx), 32'h97);
        wait_idle("lat_idle");
        exp_req = exp_req + 8'd1;
        check("lat_cnt", 32'(req_count), 32'(exp_req));

        // CRC vectors
        do_reply(8'h01, 8'h07, "crc01");
        do_reply(8'hFF, 8'hF3, "crcFF");
        do_reply(8'h00, 8'h00, "crc00");

        // Wrong address is ignored
        p0 = pulse_cnt;
        send_req(8'h02, 8'h55);
        check("addr_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        check("addr_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("addr_cnt", 32'(req_count), 32'(exp_req));

        // Transmitter in use at FREE1
        hold_test(1'b0, "hold_act");
        hold_test(1'b1, "hold_done");

        // Second request during WAIT1 is dropped
        p0 = pulse_cnt;
        send_req(8'h01, 8'h01);
        wait_pulse("mid_p1");
        send_req(8'h01, 8'hFF);
        wait_pulse("mid_p2");
        check("mid_crc", 32'(bus.data_tx), 32'h07);
        wait_idle("mid_idle");
        repeat (20) tick();
        check("mid_pulses", 32'(pulse_cnt - p0), 32'd2);
        exp_req = exp_req + 8'd1;
        check("mid_cnt", 32'(req_count), 32'(exp_req));

        // Reset during WAIT1
        send_req(8'h01, 8'h31);
        wait_pulse("rw_p1");
        tick();
        check("rw_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rw_data_tx", 32'(bus.data_tx), 32'h00);
        check("rw_enable_tx", 32'(bus.enable_tx), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_req_count", 32'(req_count), 32'h00);
        repeat (2) tick();
        reset = 1'b0;
        exp_req = 8'h00;
        repeat (12) tick();
        do_reply(8'h31, 8'h97, "post_rst");

        // Counter wrap after 256 replies
        for (int i = 0; i < 254; i++) begin
            send_req(8'h01, 8'(i));
            wait_idle("wrap_idle");
        end
        check("wrap_ff", 32'(req_count), 32'hFF);
        send_req(8'h01, 8'hA5);
        wait_idle("wrap_last_idle");
        check("wrap_00", 32'(req_count), 32'h00);

        // Global protocol properties
        check("no_double_en", 32'(dbl_cnt), 32'd0);
        check("no_en_while_tx", 32'(viol_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
